// File: rtl/dfi_upd_arbiter.sv
// Purpose : arbitrates DFI PHY-update, PHY-master, controller-update and LP-control handshakes, one grant at a time.
// Latency : request sampled in IDLE -> DRAIN next cycle -> handshake output the cycle after cmd_idle is seen.
// Backpressure: cmd_hold stalls the MC outside IDLE; requests arriving outside IDLE wait for the next IDLE cycle.
//
// Ports:
//   clock/reset              sole clock, async active-low reset
//   init_complete, cmd_idle  PHY ready / MC path empty
//   cmd_hold                 MC must stop issuing DFI commands
//   mc_ctrlupd_req, mc_lp_req, mc_lp_wakeup, lp_active   core-side requests and LP status
//   ctrlupd_*, phyupd_*, phymstr_*, lp_ctrl_*            DFI handshakes
//   err_clr, err_status      sticky {lp no ack, ctrlupd no ack, phyupd late}
module dfi_upd_arbiter #(
    parameter int TPHYUPD_RESP = 16,
    parameter int TCTRLUPD_MIN = 4,
    parameter int TCTRLUPD_MAX = 32,
    parameter int TLP_RESP     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init_complete,
    input  logic       cmd_idle,
    output logic       cmd_hold,
    input  logic       mc_ctrlupd_req,
    input  logic       mc_lp_req,
    input  logic [5:0] mc_lp_wakeup,
    output logic       lp_active,
    output logic       ctrlupd_req,
    input  logic       ctrlupd_ack,
    input  logic       phyupd_req,
    input  logic [1:0] phyupd_type,
    output logic       phyupd_ack,
    input  logic       phymstr_req,
    input  logic [1:0] phymstr_type,
    output logic       phymstr_ack,
    output logic       lp_ctrl_req,
    output logic [5:0] lp_ctrl_wakeup,
    input  logic       lp_ctrl_ack,
    input  logic       err_clr,
    output logic [2:0] err_status
);

    localparam int PCW  = $clog2(TPHYUPD_RESP + 1);
    localparam int OMAX = (TCTRLUPD_MAX > TLP_RESP) ? TCTRLUPD_MAX : TLP_RESP;
    localparam int OCW  = $clog2(OMAX + 1);

    localparam logic [PCW-1:0] PHY_LIM = PCW'(TPHYUPD_RESP);
    localparam logic [OCW-1:0] CU_MIN  = OCW'(TCTRLUPD_MIN);
    localparam logic [OCW-1:0] CU_MAX  = OCW'(TCTRLUPD_MAX);
    localparam logic [OCW-1:0] LP_LIM  = OCW'(TLP_RESP);
    localparam logic [OCW-1:0] OP_ONE  = OCW'(1);
    localparam logic [PCW-1:0] PHY_ONE = PCW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_DRAIN, S_PHYUPD, S_PHYMSTR, S_CTRLUPD,
        S_CTRLUPD_END, S_LP_REQ, S_LP_ACTIVE, S_LP_EXIT
    } state_e;

    typedef enum logic [1:0] {G_PHYUPD, G_PHYMSTR, G_CTRLUPD, G_LP} grant_e;

    state_e         state_q, state_d;
    grant_e         grant_q, grant_d;
    logic [5:0]     wakeup_q, wakeup_d;
    logic [PCW-1:0] phy_cnt_q, phy_cnt_d;
    logic [OCW-1:0] op_cnt_q, op_cnt_d;
    logic [2:0]     err_q, err_d;
    logic           cmd_hold_q, cmd_hold_d;
    logic           lp_active_q, lp_active_d;
    logic           ctrlupd_req_q, ctrlupd_req_d;
    logic           phyupd_ack_q, phyupd_ack_d;
    logic           phymstr_ack_q, phymstr_ack_d;
    logic           lp_ctrl_req_q, lp_ctrl_req_d;

    logic           cu_timeout, lp_timeout, phy_late;
    logic           grant_live;
    state_e         grant_state;

    // The update/master type codes do not influence arbitration.
    logic unused_type;
    assign unused_type = ^{phyupd_type, phymstr_type};

    // ---------------- state / output registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            grant_q       <= G_PHYUPD;
            wakeup_q      <= '0;
            phy_cnt_q     <= '0;
            op_cnt_q      <= '0;
            err_q         <= '0;
            cmd_hold_q    <= 1'b0;
            lp_active_q   <= 1'b0;
            ctrlupd_req_q <= 1'b0;
            phyupd_ack_q  <= 1'b0;
            phymstr_ack_q <= 1'b0;
            lp_ctrl_req_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            wakeup_q      <= wakeup_d;
            phy_cnt_q     <= phy_cnt_d;
            op_cnt_q      <= op_cnt_d;
            err_q         <= err_d;
            cmd_hold_q    <= cmd_hold_d;
            lp_active_q   <= lp_active_d;
            ctrlupd_req_q <= ctrlupd_req_d;
            phyupd_ack_q  <= phyupd_ack_d;
            phymstr_ack_q <= phymstr_ack_d;
            lp_ctrl_req_q <= lp_ctrl_req_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        wakeup_d    = wakeup_q;
        cu_timeout  = 1'b0;
        lp_timeout  = 1'b0;
        grant_live  = 1'b0;
        grant_state = S_IDLE;

        // Whether the latched requester still wants service, and where it goes.
        case (grant_q)
            G_PHYUPD:  begin grant_live = phyupd_req;     grant_state = S_PHYUPD;  end
            G_PHYMSTR: begin grant_live = phymstr_req;    grant_state = S_PHYMSTR; end
            G_CTRLUPD: begin grant_live = mc_ctrlupd_req; grant_state = S_CTRLUPD; end
            default:   begin grant_live = mc_lp_req;      grant_state = S_LP_REQ;  end
        endcase

        case (state_q)
            S_IDLE: begin
                if (init_complete) begin
                    if (phyupd_req) begin
                        grant_d = G_PHYUPD;
                        state_d = S_DRAIN;
                    end else if (phymstr_req) begin
                        grant_d = G_PHYMSTR;
                        state_d = S_DRAIN;
                    end else if (mc_ctrlupd_req) begin
                        grant_d = G_CTRLUPD;
                        state_d = S_DRAIN;
                    end else if (mc_lp_req) begin
                        grant_d  = G_LP;
                        wakeup_d = mc_lp_wakeup;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // A withdrawn request cancels the grant before any handshake starts.
                if (!grant_live)   state_d = S_IDLE;
                else if (cmd_idle) state_d = grant_state;
            end
            S_PHYUPD:  if (!phyupd_req)  state_d = S_IDLE;
            S_PHYMSTR: if (!phymstr_req) state_d = S_IDLE;
            S_CTRLUPD: begin
                if (ctrlupd_ack && (op_cnt_q >= CU_MIN)) begin
                    state_d = S_CTRLUPD_END;
                end else if (op_cnt_q == CU_MAX) begin
                    state_d    = S_CTRLUPD_END;
                    cu_timeout = 1'b1;
                end
            end
            S_CTRLUPD_END: if (!ctrlupd_ack) state_d = S_IDLE;
            S_LP_REQ: begin
                if (lp_ctrl_ack) begin
                    state_d = S_LP_ACTIVE;
                end else if (op_cnt_q == LP_LIM) begin
                    state_d    = S_IDLE;
                    lp_timeout = 1'b1;
                end
            end
            S_LP_ACTIVE: if (!mc_lp_req || phyupd_req || phymstr_req) state_d = S_LP_EXIT;
            S_LP_EXIT:   if (!lp_ctrl_ack) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // Losing PHY init abandons whatever handshake is in progress.
        if (!init_complete) state_d = S_IDLE;
    end

    // ---------------- counters, error flags, registered outputs ----------------
    always_comb begin
        // Counts cycles since phyupd_req rose until phyupd_ack is seen; saturates at the limit.
        phy_cnt_d = phy_cnt_q;
        if (!phyupd_req)
            phy_cnt_d = '0;
        else if (!phyupd_ack_q && (phy_cnt_q != PHY_LIM))
            phy_cnt_d = phy_cnt_q + PHY_ONE;

        phy_late = phyupd_req && !phyupd_ack_q && (phy_cnt_q == PHY_LIM);

        // Shared handshake counter: reads 1 in the first CTRLUPD / LP_REQ cycle.
        op_cnt_d = '0;
        if ((state_d == S_CTRLUPD) || (state_d == S_LP_REQ))
            op_cnt_d = (state_q == state_d) ? (op_cnt_q + OP_ONE) : OP_ONE;

        // A set event in the same cycle as err_clr wins.
        err_d = (err_q & {3{~err_clr}}) | {lp_timeout, cu_timeout, phy_late};

        // Outputs are decoded from the next state so they are registered yet state-aligned.
        cmd_hold_d    = (state_d != S_IDLE);
        lp_active_d   = (state_d == S_LP_ACTIVE);
        ctrlupd_req_d = (state_d == S_CTRLUPD);
        phyupd_ack_d  = (state_d == S_PHYUPD);
        phymstr_ack_d = (state_d == S_PHYMSTR);
        lp_ctrl_req_d = (state_d == S_LP_REQ) || (state_d == S_LP_ACTIVE);
    end

    assign cmd_hold       = cmd_hold_q;
    assign lp_active      = lp_active_q;
    assign ctrlupd_req    = ctrlupd_req_q;
    assign phyupd_ack     = phyupd_ack_q;
    assign phymstr_ack    = phymstr_ack_q;
    assign lp_ctrl_req    = lp_ctrl_req_q;
    assign lp_ctrl_wakeup = wakeup_q;
    assign err_status     = err_q;

endmodule

// File: tb/tb_dfi_upd_arbiter.sv
// Purpose : directed cycle-by-cycle vector bench for dfi_upd_arbiter.
// Latency : vector k drives inputs of cycle k and expects the registered outputs visible in cycle k.
// Backpressure: none; inputs are driven 1 time unit after each rising edge.
module tb_dfi_upd_arbiter;

    logic       clock;
    logic       reset;
    logic       init_complete, cmd_idle, cmd_hold;
    logic       mc_ctrlupd_req, mc_lp_req, lp_active;
    logic [5:0] mc_lp_wakeup, lp_ctrl_wakeup;
    logic       ctrlupd_req, ctrlupd_ack;
    logic       phyupd_req, phyupd_ack, phymstr_req, phymstr_ack;
    logic [1:0] phyupd_type, phymstr_type;
    logic       lp_ctrl_req, lp_ctrl_ack, err_clr;
    logic [2:0] err_status;

    dfi_upd_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .init_complete  (init_complete),
        .cmd_idle       (cmd_idle),
        .cmd_hold       (cmd_hold),
        .mc_ctrlupd_req (mc_ctrlupd_req),
        .mc_lp_req      (mc_lp_req),
        .mc_lp_wakeup   (mc_lp_wakeup),
        .lp_active      (lp_active),
        .ctrlupd_req    (ctrlupd_req),
        .ctrlupd_ack    (ctrlupd_ack),
        .phyupd_req     (phyupd_req),
        .phyupd_type    (phyupd_type),
        .phyupd_ack     (phyupd_ack),
        .phymstr_req    (phymstr_req),
        .phymstr_type   (phymstr_type),
        .phymstr_ack    (phymstr_ack),
        .lp_ctrl_req    (lp_ctrl_req),
        .lp_ctrl_wakeup (lp_ctrl_wakeup),
        .lp_ctrl_ack    (lp_ctrl_ack),
        .err_clr        (err_clr),
        .err_status     (err_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ib = {init_complete, cmd_idle, mc_ctrlupd_req, mc_lp_req, phyupd_req, phymstr_req, ctrlupd_ack, lp_ctrl_ack, err_clr}
    // ob = {cmd_hold, lp_active, ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req}
    typedef struct {
        string      name;
        logic [8:0] ib;
        logic [5:0] iw;
        logic [5:0] ob;
        logic [5:0] ow;
        logic [2:0] oe;
    } vec_t;

    localparam logic [8:0] IDLE_IN = 9'b11_00_00_00_0;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input string nm, input logic [8:0] ib, input logic [5:0] iw,
                       input logic [5:0] ob, input logic [5:0] ow, input logic [2:0] oe);
        vec_t v;
        v.name = nm; v.ib = ib; v.iw = iw; v.ob = ob; v.ow = ow; v.oe = oe;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [8:0] ib, input logic [5:0] iw);
        {init_complete, cmd_idle, mc_ctrlupd_req, mc_lp_req, phyupd_req,
         phymstr_req, ctrlupd_ack, lp_ctrl_ack, err_clr} = ib;
        mc_lp_wakeup = iw;
    endtask

    task automatic check(input string nm, input logic [5:0] eo, input logic [5:0] ew, input logic [2:0] ee);
        logic [5:0] ao;
        ao = {cmd_hold, lp_active, ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req};
        n_vec++;
        if (ao !== eo || lp_ctrl_wakeup !== ew || err_status !== ee) begin
            n_bad++;
            $display("FAIL %s @%0t: got out=%b wake=%h err=%b, want out=%b wake=%h err=%b",
                     nm, $time, ao, lp_ctrl_wakeup, err_status, eo, ew, ee);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        phyupd_type  = 2'b01;
        phymstr_type = 2'b10;
        reset        = 1'b0;
        // Requests present during reset must not leak through.
        drive(9'b11_11_11_11_0, 6'h2A);

        // ---- basic PHY update ----
        add("pu_c0",    9'b11_00_10_00_0, 6'h00, 6'b000000, 6'h00, 3'b000);
        add("pu_drain", 9'b11_00_10_00_0, 6'h00, 6'b100000, 6'h00, 3'b000);
        for (int k = 2; k <= 9; k++)
            add("pu_ack", 9'b11_00_10_00_0, 6'h00, 6'b100100, 6'h00, 3'b000);
        add("pu_fall",  IDLE_IN,          6'h00, 6'b100100, 6'h00, 3'b000);
        add("pu_done",  IDLE_IN,          6'h00, 6'b000000, 6'h00, 3'b000);

        // ---- controller update, ack from counter 1 ----
        add("cu_c0",    9'b11_10_00_00_0, 6'h00, 6'b000000, 6'h00, 3'b000);
        add("cu_drain", 9'b11_10_00_00_0, 6'h00, 6'b100000, 6'h00, 3'b000);
        for (int k = 2; k <= 5; k++)
            add("cu_req", 9'b11_10_00_10_0, 6'h00, 6'b101000, 6'h00, 3'b000);
        add("cu_end",   9'b11_00_00_10_0, 6'h00, 6'b100000, 6'h00, 3'b000);
        add("cu_end2",  IDLE_IN,          6'h00, 6'b100000, 6'h00, 3'b000);
        add("cu_idle",  IDLE_IN,          6'h00, 6'b000000, 6'h00, 3'b000);

        // ---- simultaneous phyupd + ctrlupd ----
        add("sim_c0",     9'b11_10_10_00_0, 6'h00, 6'b000000, 6'h00, 3'b000);
        add("sim_drain",  9'b11_10_10_00_0, 6'h00, 6'b100000, 6'h00, 3'b000);
        add("sim_pu",     9'b11_10_10_00_0, 6'h00, 6'b100100, 6'h00, 3'b000);
        add("sim_pu",     9'b11_10_10_00_0, 6'h00, 6'b100100, 6'h00, 3'b000);
        add("sim_pufall", 9'b11_10_00_00_0, 6'h00, 6'b100100, 6'h00, 3'b000);
        add("sim_gap",    9'b11_10_00_00_0, 6'h00, 6'b000000, 6'h00, 3'b000);
        add("sim_drain2", 9'b11_10_00_00_0, 6'h00, 6'b100000, 6'h00, 3'b000);
        for (int k = 7; k <= 10; k++)
            add("sim_cu", 9'b11_10_00_10_0, 6'h00, 6'b101000, 6'h00, 3'b000);
        add("sim_cuend",  IDLE_IN,          6'h00, 6'b100000, 6'h00, 3'b000);
        add("sim_idle",   IDLE_IN,          6'h00, 6'b000000, 6'h00, 3'b000);

        // ---- LP with no ack; err_clr coincides with the timeout ----
        add("lp_c0",    9'b11_01_00_00_0, 6'h0A, 6'b000000, 6'h00, 3'b000);
        add("lp_drain", 9'b11_01_00_00_0, 6'h3F, 6'b100000, 6'h0A, 3'b000);
        for (int k = 2; k <= 8; k++)
            add("lp_req", 9'b11_01_00_00_0, 6'h3F, 6'b100001, 6'h0A, 3'b000);
        add("lp_last",  9'b11_00_00_00_1, 6'h3F, 6'b100001, 6'h0A, 3'b000);
        add("lp_tmo",   IDLE_IN,          6'h00, 6'b000000, 6'h0A, 3'b100);
        add("lp_clr",   9'b11_00_00_00_1, 6'h00, 6'b000000, 6'h0A, 3'b100);
        add("lp_clred", IDLE_IN,          6'h00, 6'b000000, 6'h0A, 3'b000);

        // ---- PHY master ----
        add("pm_c0",    9'b11_00_01_00_0, 6'h00, 6'b000000, 6'h0A, 3'b000);
        add("pm_drain", 9'b11_00_01_00_0, 6'h00, 6'b100000, 6'h0A, 3'b000);
        add("pm_ack",   9'b11_00_01_00_0, 6'h00, 6'b100010, 6'h0A, 3'b000);
        add("pm_fall",  IDLE_IN,          6'h00, 6'b100010, 6'h0A, 3'b000);
        add("pm_done",  IDLE_IN,          6'h00, 6'b000000, 6'h0A, 3'b000);

        // ---- request withdrawn during DRAIN ----
        add("cx_c0",    9'b10_10_00_00_0, 6'h00, 6'b000000, 6'h0A, 3'b000);
        add("cx_drain", 9'b10_10_00_00_0, 6'h00, 6'b100000, 6'h0A, 3'b000);
        add("cx_drop",  9'b10_00_00_00_0, 6'h00, 6'b100000, 6'h0A, 3'b000);
        add("cx_idle",  IDLE_IN,          6'h00, 6'b000000, 6'h0A, 3'b000);
        add("cx_idle2", IDLE_IN,          6'h00, 6'b000000, 6'h0A, 3'b000);

        // ---- no grant while init_complete=0 ----
        add("ni_c0",   9'b01_10_10_00_0, 6'h00, 6'b000000, 6'h0A, 3'b000);
        add("ni_hold", 9'b01_10_10_00_0, 6'h00, 6'b000000, 6'h0A, 3'b000);
        add("ni_hold", 9'b01_10_10_00_0, 6'h00, 6'b000000, 6'h0A, 3'b000);
        add("ni_rel",  IDLE_IN,          6'h00, 6'b000000, 6'h0A, 3'b000);

        // ---- ctrlupd without ack: 32-cycle timeout ----
        add("ct_c0",    9'b11_10_00_00_0, 6'h00, 6'b000000, 6'h0A, 3'b000);
        add("ct_drain", 9'b11_10_00_00_0, 6'h00, 6'b100000, 6'h0A, 3'b000);
        for (int k = 2; k <= 32; k++)
            add("ct_wait", 9'b11_10_00_00_0, 6'h00, 6'b101000, 6'h0A, 3'b000);
        add("ct_max",   IDLE_IN,          6'h00, 6'b101000, 6'h0A, 3'b000);
        add("ct_end",   IDLE_IN,          6'h00, 6'b100000, 6'h0A, 3'b010);
        add("ct_clr",   9'b11_00_00_00_1, 6'h00, 6'b000000, 6'h0A, 3'b010);
        add("ct_clred", IDLE_IN,          6'h00, 6'b000000, 6'h0A, 3'b000);

        // ---- LP accepted, then PHY update forces exit ----
        add("lpa_c0",     9'b11_01_00_00_0, 6'h15, 6'b000000, 6'h0A, 3'b000);
        add("lpa_drain",  9'b11_01_00_00_0, 6'h15, 6'b100000, 6'h15, 3'b000);
        add("lpa_req",    9'b11_01_00_00_0, 6'h15, 6'b100001, 6'h15, 3'b000);
        add("lpa_ack",    9'b11_01_00_01_0, 6'h15, 6'b100001, 6'h15, 3'b000);
        add("lpa_act",    9'b11_01_00_01_0, 6'h15, 6'b110001, 6'h15, 3'b000);
        add("lpa_pu",     9'b11_01_10_01_0, 6'h15, 6'b110001, 6'h15, 3'b000);
        add("lpa_exit",   9'b11_00_10_01_0, 6'h15, 6'b100000, 6'h15, 3'b000);
        add("lpa_ackdn",  9'b11_00_10_00_0, 6'h15, 6'b100000, 6'h15, 3'b000);
        add("lpa_idle",   9'b11_00_10_00_0, 6'h15, 6'b000000, 6'h15, 3'b000);
        add("lpa_drain2", 9'b11_00_10_00_0, 6'h15, 6'b100000, 6'h15, 3'b000);
        add("lpa_puack",  9'b11_00_10_00_0, 6'h15, 6'b100100, 6'h15, 3'b000);
        add("lpa_pufall", IDLE_IN,          6'h15, 6'b100100, 6'h15, 3'b000);
        add("lpa_done",   IDLE_IN,          6'h15, 6'b000000, 6'h15, 3'b000);

        // ---- long drain: PHY response late flag at exactly 16 cycles ----
        add("dr_c0", 9'b10_00_10_00_0, 6'h00, 6'b000000, 6'h15, 3'b000);
        for (int k = 1; k <= 16; k++)
            add("dr_wait", 9'b10_00_10_00_0, 6'h00, 6'b100000, 6'h15, 3'b000);
        for (int k = 17; k <= 19; k++)
            add("dr_late", 9'b10_00_10_00_0, 6'h00, 6'b100000, 6'h15, 3'b001);
        add("dr_idle", 9'b11_00_10_00_0, 6'h00, 6'b100000, 6'h15, 3'b001);
        add("dr_ack",  9'b11_00_10_00_0, 6'h00, 6'b100100, 6'h15, 3'b001);
        add("dr_ack2", 9'b11_00_10_00_0, 6'h00, 6'b100100, 6'h15, 3'b001);

        // ---- reset state ----
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 6'b000000, 6'h00, 3'b000);
        drive(IDLE_IN, 6'h00);
        #2 reset = 1'b1;

        // ---- table ----
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clock);
            #1;
            drive(tbl[i].ib, tbl[i].iw);
            check(tbl[i].name, tbl[i].ob, tbl[i].ow, tbl[i].oe);
        end

        // ---- reset asserted in the middle of phyupd_ack ----
        @(posedge clock);
        #1;
        check("rst_pre", 6'b100100, 6'h15, 3'b001);
        #2 reset = 1'b0;
        #1;
        check("rst_async", 6'b000000, 6'h00, 3'b000);
        @(posedge clock);
        #1;
        check("rst_hold", 6'b000000, 6'h00, 3'b000);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_drain", 6'b100000, 6'h00, 3'b000);
        @(posedge clock);
        #1;
        drive(IDLE_IN, 6'h00);
        check("rst_ack", 6'b100100, 6'h00, 3'b000);
        @(posedge clock);
        #1;
        check("rst_done", 6'b000000, 6'h00, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
